// File: rtl/slave_rr_arbiter_pkg.sv
// slave_rr_arbiter_pkg: shared arbiter state encoding and slave-side mux select sizing
package slave_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Slave-side mux select width: 0 means none, k+1 selects master k
  function automatic int muxsel_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Master index width
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slave_rr_arbiter_picker.sv
// rr_priority_picker: first eligible requester scanning from a start index with wraparound
module rr_priority_picker
  import slave_rr_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  excl,
  output logic          found,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  // Walk the ring start, start+1, ... and take the first unmasked requester
  always_comb begin
    int k;
    k      = 0;
    found  = 1'b0;
    onehot = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      k = (int'(start) + i) % N;
      if (!found && req[k] && !excl[k]) begin
        found     = 1'b1;
        onehot[k] = 1'b1;
        idx       = IW'(k);
      end
    end
  end

endmodule

// File: rtl/slave_rr_arbiter.sv
// slave_rr_arbiter: round-robin slave-port arbiter with registered grants, lock hold and lock watchdog
module slave_rr_arbiter
  import slave_rr_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS  = 2,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic [NUM_MASTERS-1:0]           i_Req,
  input  logic [NUM_MASTERS-1:0]           i_Lock,
  output logic [NUM_MASTERS-1:0]           o_Gnt,
  output logic [muxsel_w(NUM_MASTERS)-1:0] o_MuxSel,
  output logic                             o_Timeout
);

  localparam int IW    = idx_w(NUM_MASTERS);
  localparam int MW    = muxsel_w(NUM_MASTERS);
  localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);

  state_t                 state, state_n;
  logic [IW-1:0]          last, last_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [NUM_MASTERS-1:0] gnt_n, excl, pick_oh;
  logic [MW-1:0]          mux_n;
  logic                   to_n;
  logic [IW-1:0]          start, pick_idx;
  logic                   found, owner_lock, waiting, revoke, hold;

  // Scan begins just after the last granted master, so the previous owner ranks lowest
  assign start      = (last == IW'(NUM_MASTERS - 1)) ? '0 : last + IW'(1);
  assign owner_lock = (state == OWNED) && |(i_Lock & o_Gnt);
  assign waiting    = |(i_Req & ~o_Gnt);
  assign revoke     = (LOCK_TIMEOUT != 0) && owner_lock && waiting && (cnt == CNT_MAX);
  assign hold       = owner_lock && !revoke;
  assign excl       = revoke ? o_Gnt : '0;

  rr_priority_picker #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req    (i_Req),
    .start  (start),
    .excl   (excl),
    .found  (found),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // Next state: hold a live lock (counting waiting cycles), otherwise re-arbitrate
  always_comb begin
    state_n = state;
    gnt_n   = o_Gnt;
    mux_n   = o_MuxSel;
    last_n  = last;
    cnt_n   = cnt;
    to_n    = 1'b0;
    if (hold) begin
      cnt_n = (waiting && cnt != CNT_MAX) ? cnt + CNT_W'(1) : cnt;
    end else begin
      state_n = found ? OWNED : IDLE;
      gnt_n   = pick_oh;
      mux_n   = found ? MW'(pick_idx) + MW'(1) : '0;
      last_n  = found ? pick_idx : last;
      cnt_n   = '0;
      to_n    = revoke;
    end
  end

  // State, round-robin pointer, lock counter and registered outputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= IDLE;
      last      <= IW'(NUM_MASTERS - 1);
      cnt       <= '0;
      o_Gnt     <= '0;
      o_MuxSel  <= '0;
      o_Timeout <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      cnt       <= cnt_n;
      o_Gnt     <= gnt_n;
      o_MuxSel  <= mux_n;
      o_Timeout <= to_n;
    end
  end

endmodule
